io16_scan_ctrl: RTL and testbench

Serial scan controller for the 16-channel IO expander. It shifts a 16-bit LED image out to a 74HC595-style output chain and, at the same time, shifts a 16-bit switch image in from a 74HC165-style input chain. A new frame starts periodically, paced by the 1 MHz strobe. It replaces direct per-pin wiring so that S1..S16/D1..D16 reach the board over five wires.

---
 rtl/io16_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_io16_scan_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/io16_scan_ctrl.sv
// Serial scan controller: shifts an LED image out to a 595-style chain while
// shifting a switch image in from a 165-style chain, one frame per period.
module io16_scan_ctrl #(
  parameter int N_BITS   = 16,
  parameter int SCAN_GAP = 965
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLK_1MHz,
  input  logic              EN,
  input  logic [N_BITS-1:0] LED_DATA,
  input  logic              SER_DI,
  output logic              SER_CLK,
  output logic              SER_DO,
  output logic              SER_LATCH,
  output logic              SER_LOAD_N,
  output logic [N_BITS-1:0] SW_DATA,
  output logic              SW_VALID,
  output logic              BUSY
);

  localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int GW = (SCAN_GAP > 0) ? $clog2(SCAN_GAP + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(N_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((SCAN_GAP > 0) ? SCAN_GAP - 1 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, GAP} state_t;

  state_t            state, state_nx;
  logic [2:0]        sync_q;
  logic              tick;
  logic [N_BITS-1:0] tx_shift, rx_shift;
  logic [BW-1:0]     bitcnt;
  logic [GW-1:0]     gapcnt;

  // two sync stages, one edge register, registered tick: 3 CLK after the rise
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], CLK_1MHz};
      tick   <= sync_q[1] & ~sync_q[2];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (tick) begin
      case (state)
        IDLE:     if (EN) state_nx = LOAD;
        LOAD:     state_nx = SHIFT_LO;
        SHIFT_LO: state_nx = SHIFT_HI;
        SHIFT_HI: state_nx = (bitcnt == BIT_LAST) ? LATCH : SHIFT_LO;
        LATCH:    state_nx = (SCAN_GAP == 0) ? IDLE : GAP;
        GAP:      if (gapcnt == GAP_LAST) state_nx = IDLE;
        default:  state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_shift   <= '0;
      rx_shift   <= '0;
      bitcnt     <= '0;
      gapcnt     <= '0;
      SER_CLK    <= 1'b0;
      SER_DO     <= 1'b0;
      SER_LATCH  <= 1'b0;
      SER_LOAD_N <= 1'b1;
      SW_DATA    <= '0;
      SW_VALID   <= 1'b0;
    end else begin
      SW_VALID <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: if (EN) begin
            tx_shift   <= LED_DATA;
            SER_LOAD_N <= 1'b0;
          end
          LOAD: begin
            SER_LOAD_N <= 1'b1;
            SER_DO     <= tx_shift[N_BITS-1];
            bitcnt     <= '0;
          end
          // sample Q_H while SER_CLK is still low
          SHIFT_LO: begin
            rx_shift <= {rx_shift[N_BITS-2:0], SER_DI};
            SER_CLK  <= 1'b1;
          end
          SHIFT_HI: begin
            SER_CLK <= 1'b0;
            if (bitcnt == BIT_LAST) begin
              SER_LATCH <= 1'b1;
            end else begin
              bitcnt   <= bitcnt + 1'b1;
              tx_shift <= tx_shift << 1;
              SER_DO   <= tx_shift[N_BITS-2];
            end
          end
          LATCH: begin
            SER_LATCH <= 1'b0;
            SW_DATA   <= rx_shift;
            SW_VALID  <= 1'b1;
            gapcnt    <= '0;
          end
          GAP:     gapcnt <= gapcnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_io16_scan_ctrl.sv
// Bench for io16_scan_ctrl: chain models on both sides, scoreboard of expected
// switch/LED images popped on SW_VALID; one default DUT and one with no gap.
module tb_io16_scan_ctrl;
  typedef struct packed {logic [15:0] sw; logic [15:0] led;} exp_t;

  logic CLK = 1'b0, RST = 1'b1, CLK_1MHz = 1'b0;
  logic EN0 = 1'b0, EN1 = 1'b0;
  logic [15:0] LED0 = '0, LED1 = '0;
  logic DI0, DI1;
  logic sclk0, sdo0, lat0, ldn0, swv0, busy0;
  logic sclk1, sdo1, lat1, ldn1, swv1, busy1;
  logic [15:0] sw_data0, sw_data1;

  int checks = 0, errors = 0, cyc = 0;
  int falls0 = 0, rises0 = 0, valids0 = 0, lats0 = 0;
  int falls1 = 0, rises1 = 0, valids1 = 0;
  int fall_cyc0[16], fall_rise0[16], fall_cyc1[16], fall_rise1[16];
  logic [15:0] sw_in0 = '0, in_sr0 = '0, out_sr0 = '0, led_q0 = '0;
  logic [15:0] sw_in1 = 16'h1234, in_sr1 = '0, out_sr1 = '0, led_q1 = '0;
  logic prev0 = 1'b0, prev1 = 1'b0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;

  always #5 CLK = ~CLK;
  always #20 CLK_1MHz = ~CLK_1MHz;
  always @(posedge CLK) cyc++;

  io16_scan_ctrl u0 (
    .CLK(CLK), .RST(RST), .CLK_1MHz(CLK_1MHz), .EN(EN0), .LED_DATA(LED0), .SER_DI(DI0),
    .SER_CLK(sclk0), .SER_DO(sdo0), .SER_LATCH(lat0), .SER_LOAD_N(ldn0),
    .SW_DATA(sw_data0), .SW_VALID(swv0), .BUSY(busy0));

  io16_scan_ctrl #(.N_BITS(16), .SCAN_GAP(0)) u1 (
    .CLK(CLK), .RST(RST), .CLK_1MHz(CLK_1MHz), .EN(EN1), .LED_DATA(LED1), .SER_DI(DI1),
    .SER_CLK(sclk1), .SER_DO(sdo1), .SER_LATCH(lat1), .SER_LOAD_N(ldn1),
    .SW_DATA(sw_data1), .SW_VALID(swv1), .BUSY(busy1));

  // 165 input chain and 595 output chain, one pair per DUT
  assign DI0 = in_sr0[15];
  assign DI1 = in_sr1[15];

  always @(negedge ldn0 or posedge sclk0) begin
    if (!ldn0) begin
      in_sr0 <= sw_in0;
      if (falls0 < 16) begin fall_cyc0[falls0] = cyc; fall_rise0[falls0] = rises0; end
      falls0++;
    end else begin
      in_sr0  <= {in_sr0[14:0], 1'b0};
      out_sr0 <= {out_sr0[14:0], sdo0};
      rises0++;
    end
  end

  always @(negedge ldn1 or posedge sclk1) begin
    if (!ldn1) begin
      in_sr1 <= sw_in1;
      if (falls1 < 16) begin fall_cyc1[falls1] = cyc; fall_rise1[falls1] = rises1; end
      falls1++;
    end else begin
      in_sr1  <= {in_sr1[14:0], 1'b0};
      out_sr1 <= {out_sr1[14:0], sdo1};
      rises1++;
    end
  end

  always @(posedge lat0) begin led_q0 = out_sr0; lats0++; end
  always @(posedge lat1) led_q1 = out_sr1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitors
  always @(negedge CLK) begin
    if (swv0) begin
      valids0++;
      chk("sw_valid0_single", 32'(prev0), 0);
      chk("q0_has_entry", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        chk("sw_data0", 32'(sw_data0), 32'(e0.sw));
        chk("led_image0", 32'(led_q0), 32'(e0.led));
      end
    end
    prev0 = swv0;
    if (swv1) begin
      valids1++;
      chk("sw_valid1_single", 32'(prev1), 0);
      chk("q1_has_entry", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("sw_data1", 32'(sw_data1), 32'(e1.sw));
        chk("led_image1", 32'(led_q1), 32'(e1.led));
      end
    end
    prev1 = swv1;
  end

  function automatic int cnt(input int sel);
    case (sel)
      0: return falls0;
      1: return rises0;
      2: return valids0;
      3: return falls1;
      4: return valids1;
      default: return 0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int target, input int budget, input string name);
    int n = 0;
    while (cnt(sel) < target && n < budget) begin @(negedge CLK); n++; end
    chk({name, "_reached"}, 32'(cnt(sel) >= target), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit hit, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, b1;
    repeat (5) @(negedge CLK);
    chk("rst_ctrl0", 32'({sclk0, sdo0, lat0, ldn0, swv0, busy0}), 32'(6'b000100));
    chk("rst_sw0", 32'(sw_data0), 0);
    chk("rst_ctrl1", 32'({sclk1, sdo1, lat1, ldn1, swv1, busy1}), 32'(6'b000100));
    RST = 1'b0;

    // disabled: 20000 CLK = 5000 ticks with nothing happening
    for (int i = 0; i < 200; i++) begin
      repeat (100) @(negedge CLK);
      chk("idle_ctrl", 32'({busy0, ldn0, sclk0, lat0}), 32'(4'b0100));
    end
    chk("idle_no_valid", valids0, 0);
    chk("idle_no_load", falls0, 0);

    // reset while SER_CLK is high for bit 7
    LED0 = 16'hFFFF; sw_in0 = 16'hFFFF; EN0 = 1'b1;
    wait_for(0, 1, 200, "abort_start");
    wait_for(1, fall_rise0[0] + 8, 400, "abort_bit7");
    EN0 = 1'b0;
    RST = 1'b1;
    #1;
    chk("rst_mid_ctrl", 32'({sclk0, sdo0, lat0, ldn0, swv0, busy0}), 32'(6'b000100));
    chk("rst_mid_sw", 32'(sw_data0), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (50) @(negedge CLK);
    chk("rst_no_valid", valids0, 0);

    // three continuous frames; images change mid-frame, EN drops in bit 3 of frame 3
    base = falls0;
    LED0 = 16'hA5C3; sw_in0 = 16'h3C5A; q0.push_back({16'h3C5A, 16'hA5C3});
    EN0 = 1'b1;
    wait_for(0, base + 1, 200, "f1_start");
    repeat (20) @(negedge CLK);
    LED0 = 16'h0F0F; sw_in0 = 16'hF0F0; q0.push_back({16'hF0F0, 16'h0F0F});
    wait_for(0, base + 2, 5000, "f2_start");
    repeat (20) @(negedge CLK);
    LED0 = 16'h8001; sw_in0 = 16'h0001; q0.push_back({16'h0001, 16'h8001});
    wait_for(0, base + 3, 5000, "f3_start");
    wait_for(1, fall_rise0[base + 2] + 4, 200, "f3_bit3");
    EN0 = 1'b0;
    wait_for(2, 3, 1000, "f3_valid");
    chk("period_1", fall_cyc0[base + 1] - fall_cyc0[base], 4000);
    chk("period_2", fall_cyc0[base + 2] - fall_cyc0[base + 1], 4000);
    chk("pulses_f1", fall_rise0[base + 1] - fall_rise0[base], 16);
    chk("pulses_f2", fall_rise0[base + 2] - fall_rise0[base + 1], 16);
    chk("pulses_f3", rises0 - fall_rise0[base + 2], 16);
    chk("latch_count", lats0, 3);
    repeat (4400) @(negedge CLK);
    chk("no_restart", falls0, base + 3);
    chk("idle_after_drop", 32'(busy0), 0);
    chk("sw_hold", 32'(sw_data0), 32'h0001);
    chk("valid_count0", valids0, 3);
    chk("q0_empty", q0.size(), 0);

    // no gap: back-to-back frames, LED change mid-frame lands in the next frame
    b1 = falls1;
    LED1 = 16'h0001; q1.push_back({16'h1234, 16'h0001});
    EN1 = 1'b1;
    wait_for(3, b1 + 1, 200, "g0_f1");
    repeat (40) @(negedge CLK);
    LED1 = 16'h8000; q1.push_back({16'h1234, 16'h8000});
    wait_for(3, b1 + 2, 400, "g0_f2");
    EN1 = 1'b0;
    wait_for(4, 2, 400, "g0_valids");
    repeat (200) @(negedge CLK);
    chk("g0_period", fall_cyc1[b1 + 1] - fall_cyc1[b1], 140);
    chk("g0_pulses", fall_rise1[b1 + 1] - fall_rise1[b1], 16);
    chk("g0_no_restart", falls1, b1 + 2);
    chk("valid_count1", valids1, 2);
    chk("q1_empty", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
